pc_gen: RTL and testbench

//  Parametrised fetch-address generator for the MIPS32 front end. Holds the PC, issues fetch requests to

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_redirect_hold.sv | 29 ++
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-address generator.
package pc_gen_pkg;

  // RUN: no redirect held; PEND: a branch target waits for the current fetch;
  // HALT: misaligned redirect taken, fetching stopped until flush.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Bit of the CTRL stall vector that freezes the fetch stage.
  localparam int STALL_FETCH_BIT = 0;

  // Sequential PC step for 32-bit MIPS instructions.
  localparam int DEFAULT_INSN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request channel between pc_gen and instruction memory.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              ce;

  modport master (
    output req_valid,
    output req_pc,
    output ce,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    input  ce,
    output req_ready
  );

endinterface

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: holds one branch target that arrived while the current
// fetch was not yet accepted. A new load overwrites the held target.
module pc_redirect_hold #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              pend_v,
  output logic [ADDR_W-1:0] pend_pc
);

  // Valid flag: clear wins over load so a flush or fire never leaves a stale target.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst)        pend_v <= 1'b0;
    else if (clear) pend_v <= 1'b0;
    else if (load)  pend_v <= 1'b1;
  end

  // Target storage, captured on every load.
  always_ff @(posedge clk) begin
    // NOTE: pend_pc is only read while pend_v is set, so it needs no reset.
    if (load) pend_pc <= load_pc;
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: MIPS32 fetch-address generator. Holds the PC, issues fetch
// requests over a valid/ready handshake, applies flush and branch redirects,
// and defers a branch that arrives before the current fetch is accepted so the
// delay slot is still fetched.
// Optional feature: define PC_GEN_ALIGN_CHK_EN to flag misaligned redirect
// targets (misalign_o pulse, fetch halted until flush_i).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INSN_BYTES = DEFAULT_INSN_BYTES,
  parameter int                STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  flush_pc_i,
  input  logic               br_valid_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  pc_gen_if.master           fetch,
  output logic               misalign_o
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, ce_q, misalign_q;
  logic              fire, redirect, bad_target;
  logic              pend_v, pend_load, pend_clear;
  logic [ADDR_W-1:0] pend_pc, redirect_pc;
  logic              unused_stall;

  // Only the fetch-stage stall bit matters here.
  assign unused_stall = ^stall_i;

  assign fire        = valid_q & fetch.req_ready & ~stall_i[STALL_FETCH_BIT];
  assign redirect    = br_valid_i | pend_v;
  // A fresh branch beats a held one.
  assign redirect_pc = br_valid_i ? br_target_i : pend_pc;

`ifdef PC_GEN_ALIGN_CHK_EN
  assign bad_target = ~flush_i & fire & redirect & (redirect_pc[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  assign pend_clear = flush_i | fire;
  assign pend_load  = br_valid_i & ~flush_i & ~fire & (state_q != HALT);

  pc_redirect_hold #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .clear   (pend_clear),
    .load    (pend_load),
    .load_pc (br_target_i),
    .pend_v  (pend_v),
    .pend_pc (pend_pc)
  );

  // Next-state logic: track whether a redirect is held, or halt on a bad target.
  always_comb begin
    // NOTE: defaults assigned first keep this block free of inferred latches.
    state_d = state_q;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN, PEND: begin
          if (fire)            state_d = bad_target ? HALT : RUN;
          else if (br_valid_i) state_d = PEND;
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // Next-PC mux: flush > fire with redirect > fire sequential > hold.
  always_comb begin
    pc_d = pc_q;
    if (flush_i)       pc_d = flush_pc_i;
    else if (fire)     pc_d = redirect ? redirect_pc : pc_q + ADDR_W'(INSN_BYTES);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // PC and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= (state_d != HALT);
      ce_q       <= 1'b1;
      misalign_q <= bad_target;
    end
  end

  assign fetch.req_valid = valid_q;
  assign fetch.req_pc    = pc_q;
  assign fetch.ce        = ce_q;
  assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked
// against a cycle-level behavioural model of the fetch PC.
module tb_pc_gen;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              misalign;

  pc_gen_if #(.ADDR_W(ADDR_W)) fetch_if ();

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .br_valid_i  (br_valid),
    .br_target_i (br_target),
    .fetch       (fetch_if),
    .misalign_o  (misalign)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_ce;
  logic [31:0] pend_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive(input bit f, input logic [31:0] fp, input bit b,
                       input logic [31:0] t, input bit rdy, input logic [5:0] st);
    flush              = f;
    flush_pc           = fp;
    br_valid           = b;
    br_target          = t;
    fetch_if.req_ready = rdy;
    stall              = st;
  endtask

  // Advance the model by the rules of one clock, then let the DUT take the edge.
  task automatic tick();
    bit fire;
    fire = m_valid && fetch_if.req_ready && !stall[0];
    if (rst) begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_ce    = 1'b0;
      pend_q.delete();
    end else begin
      if (flush) begin
        m_pc = flush_pc;
        pend_q.delete();
      end else if (fire) begin
        if (br_valid) begin
          m_pc = br_target;
          pend_q.delete();
        end else if (pend_q.size() > 0) begin
          m_pc = pend_q.pop_front();
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (br_valid) begin
        pend_q.delete();
        pend_q.push_back(br_target);
      end
      m_valid = 1'b1;
      m_ce    = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 6'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fetch_if.ce !== 1'b0 || fetch_if.req_valid !== 1'b0 || fetch_if.req_pc !== 32'h0 || misalign !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: ce=%b valid=%b pc=%h mis=%b, need ce=0 valid=0 pc=0 mis=0",
                 fetch_if.ce, fetch_if.req_valid, fetch_if.req_pc, misalign);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (fetch_if.req_pc !== 32'(i * 4) || fetch_if.req_valid !== 1'b1 || fetch_if.ce !== 1'b1) begin
        n_err++;
        $display("FAIL seq_after_reset[%0d]: pc=%h valid=%b ce=%b, need pc=%h valid=1 ce=1",
                 i, fetch_if.req_pc, fetch_if.req_valid, fetch_if.ce, 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch_hold();
    drive(1, 32'h100, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 1, 32'h400, 0, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h100 || fetch_if.req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_unaccepted: pc=%h valid=%b, need pc=00000100 valid=1", fetch_if.req_pc, fetch_if.req_valid);
    end
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h400) begin
      n_err++;
      $display("FAIL pending_applied: pc=%h, need 00000400", fetch_if.req_pc);
    end
    tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h404) begin
      n_err++;
      $display("FAIL after_pending: pc=%h, need 00000404", fetch_if.req_pc);
    end
  endtask

  task automatic test_stall();
    drive(1, 32'h20, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 0, 0, 1, 6'b000001);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fetch_if.req_pc !== 32'h20) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: pc=%h, need 00000020", i, fetch_if.req_pc);
      end
    end
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h24) begin
      n_err++;
      $display("FAIL stall_resume: pc=%h, need 00000024", fetch_if.req_pc);
    end
    drive(0, 0, 0, 0, 1, 6'b111110); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h28) begin
      n_err++;
      $display("FAIL upper_stall_ignored: pc=%h, need 00000028", fetch_if.req_pc);
    end
  endtask

  task automatic test_flush_pending();
    drive(1, 32'h100, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 1, 32'h400, 0, 6'd0); tick();
    drive(1, 32'h180, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h180) begin
      n_err++;
      $display("FAIL flush_over_pending: pc=%h, need 00000180", fetch_if.req_pc);
    end
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h184) begin
      n_err++;
      $display("FAIL pending_dropped: pc=%h, need 00000184", fetch_if.req_pc);
    end
    drive(1, 32'h300, 1, 32'h500, 1, 6'b000001); tick();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h304) begin
      n_err++;
      $display("FAIL flush_beats_branch: pc=%h, need 00000304", fetch_if.req_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1, 32'hFFFF_FFFC, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h0 || fetch_if.req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%h valid=%b, need pc=00000000 valid=1", fetch_if.req_pc, fetch_if.req_valid);
    end
  endtask

  task automatic test_branch_fire();
    drive(1, 32'h40, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 1, 32'h800, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h800) begin
      n_err++;
      $display("FAIL branch_same_cycle: pc=%h, need 00000800", fetch_if.req_pc);
    end
    drive(0, 0, 1, 32'h400, 0, 6'd0); tick();
    drive(0, 0, 1, 32'h600, 1, 6'd0); tick();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h604) begin
      n_err++;
      $display("FAIL branch_beats_pending: pc=%h, need 00000604", fetch_if.req_pc);
    end
    drive(0, 0, 1, 32'h700, 0, 6'd0); tick();
    drive(0, 0, 1, 32'h900, 0, 6'd0); tick();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h900) begin
      n_err++;
      $display("FAIL pending_overwrite: pc=%h, need 00000900", fetch_if.req_pc);
    end
  endtask

  task automatic test_misalign();
    drive(1, 32'h100, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 1, 32'h402, 1, 6'd0); tick();
`ifdef PC_GEN_ALIGN_CHK_EN
    n_cmp++;
    if (fetch_if.req_pc !== 32'h402 || misalign !== 1'b1 || fetch_if.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_detect: pc=%h mis=%b valid=%b, need pc=00000402 mis=1 valid=0",
               fetch_if.req_pc, misalign, fetch_if.req_valid);
    end
    drive(0, 0, 1, 32'h500, 1, 6'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (fetch_if.req_pc !== 32'h402 || misalign !== 1'b0 || fetch_if.req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: pc=%h mis=%b valid=%b, need pc=00000402 mis=0 valid=0",
                 i, fetch_if.req_pc, misalign, fetch_if.req_valid);
      end
    end
    drive(1, 32'h200, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h200 || fetch_if.req_valid !== 1'b1 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL halt_exit: pc=%h valid=%b mis=%b, need pc=00000200 valid=1 mis=0",
               fetch_if.req_pc, fetch_if.req_valid, misalign);
    end
`else
    n_cmp++;
    if (fetch_if.req_pc !== 32'h402 || misalign !== 1'b0 || fetch_if.req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_pass: pc=%h mis=%b valid=%b, need pc=00000402 mis=0 valid=1",
               fetch_if.req_pc, misalign, fetch_if.req_valid);
    end
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    n_cmp++;
    if (fetch_if.req_pc !== 32'h406) begin
      n_err++;
      $display("FAIL misalign_seq: pc=%h, need 00000406", fetch_if.req_pc);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 5, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 99) < 25, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 99) < 70,
            {5'($urandom), 1'($urandom_range(0, 3) == 0)});
      tick();
      n_cmp++;
      if (fetch_if.req_pc !== m_pc || fetch_if.req_valid !== m_valid ||
          fetch_if.ce !== m_ce || misalign !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d]: pc=%h valid=%b ce=%b mis=%b, need pc=%h valid=%b ce=%b mis=0",
                 i, fetch_if.req_pc, fetch_if.req_valid, fetch_if.ce, misalign,
                 m_pc, m_valid, m_ce);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch_hold();
    test_stall();
    test_flush_pending();
    test_wrap();
    test_branch_fire();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
